ifq_line_buffer: RTL and testbench

- Storage/datapath stage of the instruction fetch queue, driven by the fetch-queue controller.
- Accepts whole 128-bit cache lines (4 x 32-bit instructions) from the instruction cache on push.
- Hands one instruction per pop to decode, and advances through the words of a line before releasing the line.
- Reports empty/full/valid back to the controller; flush discards all contents on a taken branch.

---
 rtl/ifq_line_buffer.sv | 154 +++++++++++++++
 tb/tb_ifq_line_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifq_line_buffer.sv
// Instruction fetch queue line buffer.
// Stores whole cache lines (WORDS instructions each) and presents one instruction per pop.
// The buffer steps through the words of the head line, then releases that line.
// Optional macro IFQ_BYPASS_EN lets a line pushed into an empty buffer appear on dout in the same cycle.
module ifq_line_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INST_W = 32,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned PC_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push_fifo,
  input  logic [INST_W*WORDS-1:0] din_line,
  input  logic [PC_W-1:0]         din_pc,
  input  logic [1:0]              din_offset,
  input  logic                    pop_fifo,
  output logic [INST_W-1:0]       dout,
  output logic [PC_W-1:0]         dout_pc,
  output logic                    dout_valid,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic                    overflow_err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;

  // Entry storage is deliberately left out of reset.
  logic [INST_W*WORDS-1:0] line_q [DEPTH];
  logic [PC_W-1:0]         pc_q   [DEPTH];
  logic [1:0]              off_q  [DEPTH];

  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      word_idx_q, word_idx_d;
  logic            overflow_q, overflow_d;

  logic push_ok, pop_eff, bypass, byp_pop, store, release_line;
  ptr_t rd_ptr_nxt;

  // Select one instruction out of a line.
  function automatic logic [INST_W-1:0] word_sel(input logic [INST_W*WORDS-1:0] ln,
                                                 input logic [1:0] idx);
    logic [INST_W-1:0] w;
    w = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      if (k == int'(idx)) w = ln[k*INST_W +: INST_W];
    end
    return w;
  endfunction

  // Flags and the accept/consume qualifiers.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CntW'(DEPTH));
    push_ok    = push_fifo && !fifo_full && !flush;
`ifdef IFQ_BYPASS_EN
    bypass     = fifo_empty && push_fifo && !flush;
`else
    bypass     = 1'b0;
`endif
    dout_valid   = !fifo_empty || bypass;
    pop_eff      = pop_fifo && dout_valid && !flush;
    byp_pop      = bypass && pop_eff;
    // A bypassed line whose only word is consumed on arrival is never stored.
    store        = push_ok && !(byp_pop && (din_offset == 2'd3));
    release_line = pop_eff && !fifo_empty && (word_idx_q == 2'd3);
    rd_ptr_nxt   = rd_ptr_q + 1'b1;
  end

  // Head instruction and its byte address.
  always_comb begin
    dout    = '0;
    dout_pc = '0;
    if (bypass) begin
      dout    = word_sel(din_line, din_offset);
      dout_pc = din_pc + PC_W'({din_offset, 2'b00});
    end else if (!fifo_empty) begin
      dout    = word_sel(line_q[rd_ptr_q], word_idx_q);
      dout_pc = pc_q[rd_ptr_q] + PC_W'({word_idx_q, 2'b00});
    end
  end

  // Next-state for pointers, occupancy, word index and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    overflow_d = overflow_q | (push_fifo && fifo_full && !flush);
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      word_idx_d = 2'd0;
    end else begin
      if (store)        wr_ptr_d = wr_ptr_q + 1'b1;
      if (release_line) rd_ptr_d = rd_ptr_nxt;
      unique case ({store, release_line})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (fifo_empty) begin
        if (store) word_idx_d = byp_pop ? (din_offset + 2'd1) : din_offset;
      end else if (pop_eff) begin
        if (word_idx_q != 2'd3) begin
          word_idx_d = word_idx_q + 2'd1;
        end else if (count_d == '0) begin
          word_idx_d = 2'd0;
        end else if (store && (rd_ptr_nxt == wr_ptr_q)) begin
          // New head is the entry being written on this very edge.
          word_idx_d = din_offset;
        end else begin
          word_idx_d = off_q[rd_ptr_nxt];
        end
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_idx_q <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Line storage write at the tail.
  always_ff @(posedge clk) begin
    if (store) begin
      line_q[wr_ptr_q] <= din_line;
      pc_q[wr_ptr_q]   <= din_pc;
      off_q[wr_ptr_q]  <= din_offset;
    end
  end

  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_ifq_line_buffer.sv
// Scoreboard bench for ifq_line_buffer: pushes queue expected words, a monitor checks pops.
module tb_ifq_line_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         push_fifo;
  logic [127:0] din_line;
  logic [31:0]  din_pc;
  logic [1:0]   din_offset;
  logic         pop_fifo;
  logic [31:0]  dout;
  logic [31:0]  dout_pc;
  logic         dout_valid;
  logic         fifo_empty;
  logic         fifo_full;
  logic         overflow_err;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  ifq_line_buffer #(
    .DEPTH (4),
    .INST_W(32),
    .WORDS (4),
    .PC_W  (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .push_fifo   (push_fifo),
    .din_line    (din_line),
    .din_pc      (din_pc),
    .din_offset  (din_offset),
    .pop_fifo    (pop_fifo),
    .dout        (dout),
    .dout_pc     (dout_pc),
    .dout_valid  (dout_valid),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && pop_fifo && dout_valid && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %h@%h expected no output", dout, dout_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_inst", dout, e.inst);
        check("pop_pc", dout_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic enq_line(input logic [127:0] ln, input logic [31:0] pc, input logic [1:0] off);
    for (int k = int'(off); k < 4; k++) exp_q.push_back({ln[k*32 +: 32], pc + 32'(4 * k)});
  endtask

  task automatic step(input logic pu, input logic [127:0] ln, input logic [31:0] pc,
                      input logic [1:0] off, input logic po, input logic fl);
    push_fifo  = pu;
    din_line   = ln;
    din_pc     = pc;
    din_offset = off;
    pop_fifo   = po;
    flush      = fl;
    @(posedge clk);
    #1;
    push_fifo  = 1'b0;
    din_line   = '0;
    din_pc     = '0;
    din_offset = 2'd0;
    pop_fifo   = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic push(input logic [127:0] ln, input logic [31:0] pc, input logic [1:0] off,
                      input bit accept);
    if (accept) enq_line(ln, pc, off);
    step(1'b1, ln, pc, off, 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    repeat (n) step(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
  endtask

  function automatic logic [127:0] mk_line(input logic [7:0] tag);
    logic [127:0] ln;
    for (int k = 0; k < 4; k++) ln[k*32 +: 32] = {tag, 16'h0000, 8'(k)};
    return ln;
  endfunction

  logic [127:0] l0, l1, lg;

  initial begin
    reset = 1'b1; flush = 1'b0; push_fifo = 1'b0; pop_fifo = 1'b0;
    din_line = '0; din_pc = '0; din_offset = 2'd0;
    l0 = 128'h44444444_33333333_22222222_11111111;
    l1 = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    lg = 128'h0000C003_0000C002_0000C001_0000C000;
    @(posedge clk);
    #1;
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_dout_pc", dout_pc, 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    reset = 1'b0;

    // Whole line from word 0.
    push(l0, 32'h1000, 2'd0, 1'b1);
    check("l0_valid", 32'(dout_valid), 32'd1);
    check("l0_dout", dout, 32'h11111111);
    check("l0_pc", dout_pc, 32'h1000);
    pop_n(4);
    check("l0_empty", 32'(fifo_empty), 32'd1);
    check("l0_valid_after", 32'(dout_valid), 32'd0);

    // Mid-line branch target.
    push(l1, 32'h2000, 2'd2, 1'b1);
    check("off2_pc", dout_pc, 32'h2008);
    check("off2_dout", dout, 32'hCCCC0002);
    pop_n(2);
    check("off2_empty", 32'(fifo_empty), 32'd1);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 4; i++) push(mk_line(8'h50 + 8'(i)), 32'h3000 + 32'(16 * i), 2'd0, 1'b1);
    check("full_set", 32'(fifo_full), 32'd1);
    check("ovf_clear", 32'(overflow_err), 32'd0);
    push(mk_line(8'h5F), 32'h9000, 2'd0, 1'b0);
    check("ovf_set", 32'(overflow_err), 32'd1);
    check("full_hold", 32'(fifo_full), 32'd1);
    pop_n(16);
    check("drain_empty", 32'(fifo_empty), 32'd1);
    check("ovf_sticky", 32'(overflow_err), 32'd1);

    // Flush beats push and pop.
    for (int i = 0; i < 3; i++) push(mk_line(8'h60 + 8'(i)), 32'hA000 + 32'(16 * i), 2'd0, 1'b1);
    step(1'b1, mk_line(8'h6F), 32'hAF00, 2'd0, 1'b1, 1'b1);
    exp_q.delete();
    check("flush_empty", 32'(fifo_empty), 32'd1);
    check("flush_valid", 32'(dout_valid), 32'd0);
    check("flush_full", 32'(fifo_full), 32'd0);
    check("flush_ovf_kept", 32'(overflow_err), 32'd1);
    push(mk_line(8'h70), 32'hB000, 2'd0, 1'b1);
    check("post_flush_dout", dout, 32'h70000000);
    pop_n(4);

    // Asynchronous reset mid-cycle clears the sticky flag.
    reset = 1'b1;
    #2;
    check("areset_ovf", 32'(overflow_err), 32'd0);
    check("areset_empty", 32'(fifo_empty), 32'd1);
    reset = 1'b0;
    exp_q.delete();

    // Release while full with a rejected push.
    push(mk_line(8'hA0), 32'h4000, 2'd0, 1'b1);
    push(mk_line(8'hB0), 32'h5000, 2'd1, 1'b1);
    push(mk_line(8'hC0), 32'h6000, 2'd0, 1'b1);
    push(mk_line(8'hD0), 32'h7000, 2'd0, 1'b1);
    pop_n(3);
    check("rel_full_before", 32'(fifo_full), 32'd1);
    step(1'b1, mk_line(8'hE0), 32'h8000, 2'd0, 1'b1, 1'b0);
    check("rel_full_after", 32'(fifo_full), 32'd0);
    check("rel_ovf", 32'(overflow_err), 32'd1);
    check("rel_head_pc", dout_pc, 32'h5004);
    check("rel_head_dout", dout, 32'hB0000001);
    push(mk_line(8'hF0), 32'h8000, 2'd0, 1'b1);
    check("rel_count3", 32'(fifo_full), 32'd1);
    pop_n(15);
    check("rel_empty", 32'(fifo_empty), 32'd1);

    // Push into empty with a same-cycle pop.
    enq_line(lg, 32'hC000, 2'd1);
    step(1'b1, lg, 32'hC000, 2'd1, 1'b1, 1'b0);
`ifdef IFQ_BYPASS_EN
    check("byp_next_dout", dout, 32'h0000C002);
    check("byp_next_pc", dout_pc, 32'hC008);
    pop_n(2);
`else
    check("nobyp_next_dout", dout, 32'h0000C001);
    check("nobyp_next_pc", dout_pc, 32'hC004);
    pop_n(3);
`endif
    check("byp_empty", 32'(fifo_empty), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
